router_egress_queue: RTL and testbench
======================================

Name: router_egress_queue

Overview:
Sequential egress stage directly downstream of the combinational route-decision block. It accepts one flit per cycle together with its 3-bit route verdict. Rejected flits are discarded and counted. Forwarded flits are queued in a small FIFO and driven to the downstream link under credit-based flow control. This gives the purely combinational router a registered, back-pressurable output.

Parameters:
DATA_W, 30, flit payload width in bits
DEPTH, 4, FIFO depth in flits (power of two, >=2)
CREDITS, 4, initial and maximum downstream credits (>=1)
CW, $clog2(CREDITS+1), credit counter width (derived, not overridden)
QW, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream flit + verdict valid
in_ready  out  1  stage can accept a flit this cycle
in_data  in  DATA_W  flit payload
in_route  in  3  verdict: [0]=blocked, [1]=forward, [2]=priority
out_valid  out  1  flit transferred downstream this cycle (no ready; credit-gated)
out_data  out  DATA_W  head flit payload
out_prio  out  1  head flit priority bit
credit_return  in  1  downstream frees one buffer slot (1-cycle pulse)
occupancy  out  QW  flits currently queued
credits  out  CW  credits currently held
drop_count  out  8  saturating count of discarded flits
stalled  out  1  FSM in STALL
err_credit  out  1  sticky: credit_return seen with credits==CREDITS

Behaviour:
- Reset (rst=1 at edge):
  - FIFO flushed: occupancy=0, pointers=0.
  - credits=CREDITS, drop_count=0, err_credit=0.
  - FSM=IDLE; out_valid=0; out_data and out_prio=0.
  - Reset mid-transfer discards all queued flits with no partial output.
- in_ready = (occupancy < DEPTH). Combinational from registered occupancy; no dependence on in_valid or same-cycle dequeue.
- Accept = in_valid & in_ready. Enqueue iff in_route[1]=1 and in_route[0]=0; the stored entry is {in_route[2], in_data}.
- Any other accepted verdict drops the flit: drop_count+1, saturating at 255.
- Not-accepted flits (in_ready=0) are neither enqueued nor counted. Upstream must hold them.
- Transfer = (occupancy>0) & (credits>0). out_valid=transfer, out_data/out_prio = head entry, all combinational from registered state.
- On transfer, the head is popped at the clock edge.
- Minimum latency: a flit accepted at edge t is visible on out_* in cycle t+1 if the queue was empty and credits>0.
- Simultaneous enqueue + dequeue: occupancy unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Credit update:
  - transfer only: credits-1
  - credit_return only: credits+1
  - both: unchanged
  - credit_return with credits==CREDITS and no transfer: ignored, err_credit<=1 (sticky until rst)
- FSM, next state from post-update occupancy/credits:
  - IDLE (occupancy==0)
  - SEND (occupancy>0, credits>0)
  - STALL (occupancy>0, credits==0)
  - Transitions: IDLE->SEND on enqueue with credits>0; IDLE->STALL on enqueue with credits==0; SEND->STALL when credits reach 0 with flits remaining; STALL->SEND on credit_return; SEND->IDLE when the last flit pops with no enqueue.
- stalled=(state==STALL).
- out_valid is never asserted in IDLE or STALL.
- FIFO order is strict. The priority bit is carried, never used for reordering.

Test Plan:
- Reset then single forward: after rst, in_route=3'b010, in_data=0x1234567 for 1 cycle -> next cycle out_valid=1, out_data=0x1234567, out_prio=0; credits 4->3; occupancy back to 0.
- Drop path: 3 flits, in_route=3'b001, 3'b011, 3'b000 -> no out_valid; drop_count=3; occupancy=0.
- Credit exhaustion: CREDITS=4, no credit_return, 6 forward flits back-to-back -> exactly 4 out_valid pulses; then credits=0, stalled=1, occupancy=2; one credit_return -> one more transfer, then stalled=1 again.
- Full/back-pressure: credits forced to 0, 5 forward flits -> in_ready=0 once occupancy=4; the 5th is held by upstream, not counted; after one credit_return, head pops and in_ready returns to 1.
- Simultaneous events: occupancy=2, credits=2, enqueue + transfer + credit_return in the same cycle -> occupancy=2, credits=2; flit order preserved across pointer wrap (8 flits total, values 0..7 out in order).
- Error and reset: credit_return at credits=4 -> err_credit=1, credits stay 4; assert rst with occupancy=3 -> next cycle occupancy=0, out_valid=0, err_credit=0, drop_count=0.

Source files
------------

// File: rtl/router_egress_queue_if.sv
// Bundle of flit, credit and status signals between the egress queue and its neighbours.
// The slave modport is the queue's view; master is the surrounding environment.
interface router_egress_queue_if #(
  parameter int DATA_W  = 30,
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int QW = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [2:0]        in_route;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_prio;
  logic              credit_return;
  logic [QW-1:0]     occupancy;
  logic [CW-1:0]     credits;
  logic [7:0]        drop_count;
  logic              stalled;
  logic              err_credit;

  modport slave (
    input  in_valid, in_data, in_route, credit_return,
    output in_ready, out_valid, out_data, out_prio,
           occupancy, credits, drop_count, stalled, err_credit
  );

  modport master (
    output in_valid, in_data, in_route, credit_return,
    input  in_ready, out_valid, out_data, out_prio,
           occupancy, credits, drop_count, stalled, err_credit
  );
endinterface

// File: rtl/router_egress_queue.sv
// Egress stage behind the route-decision block: drops rejected flits, queues forwarded
// ones and releases them downstream under credit-based flow control.
module router_egress_queue #(
  parameter int DATA_W  = 30,
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
) (
  input logic                 clk,
  input logic                 rst,
  router_egress_queue_if.slave bus
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int QW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [QW-1:0] DEPTH_Q  = QW'(DEPTH);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  typedef enum logic [1:0] {IDLE, SEND, STALL} state_e;

  state_e          state_q, state_d;
  logic [DATA_W:0] mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [QW-1:0]   occ_q, occ_d;
  logic [CW-1:0]   cred_q, cred_d;
  logic [7:0]      drop_q, drop_d;
  logic            err_q, err_d;
  logic            in_ready, accept, enq, drop, xfer;

  assign in_ready = (occ_q < DEPTH_Q);

  always_comb begin
    accept = bus.in_valid & in_ready;
    enq    = accept & bus.in_route[1] & ~bus.in_route[0];
    drop   = accept & ~enq;
    xfer   = (occ_q != '0) & (cred_q != '0);

    occ_d = occ_q;
    if (enq & ~xfer)      occ_d = occ_q + QW'(1);
    else if (~enq & xfer) occ_d = occ_q - QW'(1);

    // A return that would overflow the pool is discarded and flagged.
    cred_d = cred_q;
    err_d  = err_q;
    if (xfer & ~bus.credit_return) begin
      cred_d = cred_q - CW'(1);
    end else if (~xfer & bus.credit_return) begin
      if (cred_q == CRED_MAX) err_d = 1'b1;
      else                    cred_d = cred_q + CW'(1);
    end

    drop_d = drop_q;
    if (drop & (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

    if (occ_d == '0)       state_d = IDLE;
    else if (cred_d == '0) state_d = STALL;
    else                   state_d = SEND;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      occ_q    <= '0;
      cred_q   <= CRED_MAX;
      drop_q   <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[PW'(i)] <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      cred_q  <= cred_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
      if (enq) begin
        mem_q[wr_ptr_q] <= {bus.in_route[2], bus.in_data};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (xfer) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = xfer;
  assign bus.out_data   = mem_q[rd_ptr_q][DATA_W-1:0];
  assign bus.out_prio   = mem_q[rd_ptr_q][DATA_W];
  assign bus.occupancy  = occ_q;
  assign bus.credits    = cred_q;
  assign bus.drop_count = drop_q;
  assign bus.stalled    = (state_q == STALL);
  assign bus.err_credit = err_q;
endmodule

// File: tb/tb_router_egress_queue.sv
// Directed bench for router_egress_queue: a queue/credit model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_router_egress_queue;
  localparam int DATA_W  = 30;
  localparam int DEPTH   = 4;
  localparam int CREDITS = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  router_egress_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CREDITS(CREDITS)) bus ();

  router_egress_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W:0]   mq[$];
  int                mcred = CREDITS;
  int                mdrop = 0;
  bit                merr  = 1'b0;
  int                nvalid = 0;
  logic [DATA_W-1:0] olog[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit mready();
    return mq.size() < DEPTH;
  endfunction

  task automatic compare_all();
    chk("in_ready",   64'(bus.in_ready),   64'(mready()));
    chk("out_valid",  64'(bus.out_valid),  64'(mq.size() > 0 && mcred > 0));
    chk("occupancy",  64'(bus.occupancy),  64'(mq.size()));
    chk("credits",    64'(bus.credits),    64'(mcred));
    chk("drop_count", 64'(bus.drop_count), 64'(mdrop));
    chk("stalled",    64'(bus.stalled),    64'(mq.size() > 0 && mcred == 0));
    chk("err_credit", 64'(bus.err_credit), 64'(merr));
    if (mq.size() > 0) begin
      chk("out_data", 64'(bus.out_data), 64'(mq[0][DATA_W-1:0]));
      chk("out_prio", 64'(bus.out_prio), 64'(mq[0][DATA_W]));
    end
  endtask

  task automatic step(input bit v, input logic [2:0] r, input logic [DATA_W-1:0] d, input bit cr);
    bit ready, xf;
    bus.in_valid      = v;
    bus.in_route      = r;
    bus.in_data       = d;
    bus.credit_return = cr;
    ready = mready();
    xf    = (mq.size() > 0) && (mcred > 0);
    if (rst) begin
      mq.delete();
      mcred = CREDITS;
      mdrop = 0;
      merr  = 1'b0;
    end else begin
      if (xf) void'(mq.pop_front());
      if (v && ready) begin
        if (r[1] && !r[0]) mq.push_back({r[2], d});
        else if (mdrop < 255) mdrop++;
      end
      if (xf && !cr) mcred--;
      else if (cr && !xf) begin
        if (mcred == CREDITS) merr = 1'b1;
        else mcred++;
      end
    end
    @(posedge clk);
    #1;
    if (bus.out_valid === 1'b1) begin
      nvalid++;
      olog.push_back(bus.out_data);
    end
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 3'b000, '0, 1'b0);
  endtask

  task automatic fwd(input logic [DATA_W-1:0] d);
    step(1'b1, 3'b010, d, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    rst = 1'b0;
  endtask

  // From reset: four flits use up every credit, leaving an empty queue with credits=0.
  task automatic drain_credits();
    for (int i = 0; i < 4; i++) fwd(DATA_W'(100 + i));
    idle();
  endtask

  initial begin
    int k;
    bus.in_valid      = 1'b0;
    bus.in_route      = 3'b000;
    bus.in_data       = '0;
    bus.credit_return = 1'b0;

    // Reset state, then a single forwarded flit.
    do_reset();
    chk("rst_occ",   64'(bus.occupancy),  64'd0);
    chk("rst_cred",  64'(bus.credits),    64'd4);
    chk("rst_valid", 64'(bus.out_valid),  64'd0);
    chk("rst_data",  64'(bus.out_data),   64'd0);
    chk("rst_prio",  64'(bus.out_prio),   64'd0);
    chk("rst_drop",  64'(bus.drop_count), 64'd0);
    chk("rst_err",   64'(bus.err_credit), 64'd0);
    step(1'b1, 3'b010, 30'h1234567, 1'b0);
    chk("single_valid", 64'(bus.out_valid), 64'd1);
    chk("single_data",  64'(bus.out_data),  64'h1234567);
    chk("single_prio",  64'(bus.out_prio),  64'd0);
    idle();
    chk("single_cred", 64'(bus.credits),   64'd3);
    chk("single_occ",  64'(bus.occupancy), 64'd0);

    // Priority flit carries its bit through.
    step(1'b1, 3'b110, 30'h2AAAAAA, 1'b0);
    chk("prio_bit", 64'(bus.out_prio), 64'd1);
    idle();

    // Drop path.
    nvalid = 0;
    step(1'b1, 3'b001, 30'h11, 1'b0);
    step(1'b1, 3'b011, 30'h22, 1'b0);
    step(1'b1, 3'b000, 30'h33, 1'b0);
    idle();
    chk("drop_cnt",    64'(bus.drop_count), 64'd3);
    chk("drop_occ",    64'(bus.occupancy),  64'd0);
    chk("drop_nvalid", 64'(nvalid),         64'd0);

    // Credit exhaustion.
    do_reset();
    nvalid = 0;
    for (int i = 0; i < 6; i++) fwd(DATA_W'(10 + i));
    repeat (3) idle();
    chk("exh_pulses",  64'(nvalid),         64'd4);
    chk("exh_cred",    64'(bus.credits),    64'd0);
    chk("exh_stalled", 64'(bus.stalled),    64'd1);
    chk("exh_occ",     64'(bus.occupancy),  64'd2);
    nvalid = 0;
    step(1'b0, 3'b000, '0, 1'b1);
    idle();
    idle();
    chk("exh_ret_pulses", 64'(nvalid),      64'd1);
    chk("exh_restall",    64'(bus.stalled), 64'd1);
    chk("exh_ret_occ",    64'(bus.occupancy), 64'd1);

    // Full queue and back-pressure; upstream holds the refused flit.
    do_reset();
    drain_credits();
    k = 0;
    for (int c = 0; c < 5; c++) begin
      bit rdy;
      rdy = mready();
      fwd(DATA_W'(200 + k));
      if (rdy) k++;
    end
    chk("full_k",     64'(k),              64'd4);
    chk("full_ready", 64'(bus.in_ready),   64'd0);
    chk("full_occ",   64'(bus.occupancy),  64'd4);
    chk("full_drop",  64'(bus.drop_count), 64'd0);
    step(1'b1, 3'b010, DATA_W'(200 + k), 1'b1);
    chk("full_ret_valid", 64'(bus.out_valid), 64'd1);
    chk("full_ret_ready", 64'(bus.in_ready),  64'd0);
    fwd(DATA_W'(200 + k));
    chk("full_pop_ready", 64'(bus.in_ready),  64'd1);
    chk("full_pop_occ",   64'(bus.occupancy), 64'd3);
    fwd(DATA_W'(200 + k));
    chk("full_refill_occ", 64'(bus.occupancy), 64'd4);

    // Simultaneous enqueue, transfer and credit return; order kept across pointer wrap.
    do_reset();
    drain_credits();
    olog.delete();
    fwd(DATA_W'(0));
    fwd(DATA_W'(1));
    step(1'b0, 3'b000, '0, 1'b1);
    chk("sim_pre_occ",  64'(bus.occupancy), 64'd2);
    chk("sim_pre_cred", 64'(bus.credits),   64'd1);
    for (int i = 2; i < 8; i++) begin
      step(1'b1, 3'b010, DATA_W'(i), 1'b1);
      chk("sim_occ",  64'(bus.occupancy), 64'd2);
      chk("sim_cred", 64'(bus.credits),   64'd1);
    end
    step(1'b0, 3'b000, '0, 1'b1);
    step(1'b0, 3'b000, '0, 1'b1);
    chk("sim_drain_occ", 64'(bus.occupancy), 64'd0);
    chk("sim_log_len",   64'(olog.size()),   64'd8);
    for (int i = 0; i < 8 && i < olog.size(); i++)
      chk("sim_order", 64'(olog[i]), 64'(i));

    // Credit overflow error, then reset with flits queued.
    do_reset();
    step(1'b0, 3'b000, '0, 1'b1);
    chk("err_set",  64'(bus.err_credit), 64'd1);
    chk("err_cred", 64'(bus.credits),    64'd4);
    step(1'b1, 3'b101, 30'h5, 1'b0);
    drain_credits();
    for (int i = 0; i < 3; i++) fwd(DATA_W'(300 + i));
    chk("pre_rst_occ",  64'(bus.occupancy),  64'd3);
    chk("pre_rst_drop", 64'(bus.drop_count), 64'd1);
    do_reset();
    chk("mid_rst_occ",   64'(bus.occupancy),  64'd0);
    chk("mid_rst_valid", 64'(bus.out_valid),  64'd0);
    chk("mid_rst_err",   64'(bus.err_credit), 64'd0);
    chk("mid_rst_drop",  64'(bus.drop_count), 64'd0);
    chk("mid_rst_cred",  64'(bus.credits),    64'd4);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
